ula_seq: RTL and testbench

Parametrised sequential ALU, the successor of the 8-bit combinational ULA.
- Generalised to WIDTH bits.
- Registered inputs/outputs with a Start/Busy/Done handshake.
- Adds iterative multiply and divide, which take multiple cycles.
- Keeps the 3-bit Flags_out encoding so downstream display/LED logic is unchanged.
- Sits between the operand/switch input stage and the BCD/display stage.

---
 rtl/ula_pkg.sv | 36 +++
 rtl/ula_seq_if.sv | 25 ++
 rtl/ula_seq_muldiv.sv | 80 ++++++++
 rtl/ula_seq.sv | 147 ++++++++++++++
 tb/tb_ula_seq.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/ula_pkg.sv
// Shared opcodes, flag codes and FSM encoding for the sequential ALU.
// Downstream display logic depends on the flag values, so they are fixed here.
package ula_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  localparam logic [2:0] FLAG_NONE  = 3'b000;
  localparam logic [2:0] FLAG_ZERO  = 3'b001;
  localparam logic [2:0] FLAG_CARRY = 3'b010;
  localparam logic [2:0] FLAG_ERR   = 3'b100;
  localparam logic [2:0] FLAG_OVF   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Only one flag code is reported; the more serious condition wins.
  function automatic logic [2:0] encode_flags(input logic err, input logic ovf,
                                              input logic carry, input logic zero);
    if (err)        return FLAG_ERR;
    else if (ovf)   return FLAG_OVF;
    else if (carry) return FLAG_CARRY;
    else if (zero)  return FLAG_ZERO;
    else            return FLAG_NONE;
  endfunction

endpackage

// File: rtl/ula_seq_if.sv
// Operand/result bus of the sequential ALU with its Start/Busy/Done handshake.
interface ula_seq_if #(parameter int WIDTH = 8);

  logic             Start_in;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic             C_in;
  logic [2:0]       Operacao_in;
  logic             Busy_out;
  logic             Done_out;
  logic [WIDTH-1:0] Saida_out;
  logic [WIDTH-1:0] Resto_out;
  logic [2:0]       Flags_out;

  modport master (
    output Start_in, A_in, B_in, C_in, Operacao_in,
    input  Busy_out, Done_out, Saida_out, Resto_out, Flags_out
  );

  modport slave (
    input  Start_in, A_in, B_in, C_in, Operacao_in,
    output Busy_out, Done_out, Saida_out, Resto_out, Flags_out
  );

endinterface

// File: rtl/ula_seq_muldiv.sv
// Iterative shift-add multiplier / restoring divider sharing one hi/lo register pair.
// Outputs present the value after the step taken this cycle, so they are final while count==1.
module ula_seq_muldiv #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             Clock_in,
  input  logic             Reset_n_in,
  input  logic             load,
  input  logic             is_div,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [CNT_W-1:0] count
);

  // hi holds the partial product (MUL) or partial remainder (DIV);
  // lo holds the multiplier being shifted out (MUL) or the dividend/quotient (DIV).
  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
  logic             div_q;
  logic [CNT_W-1:0] count_q;

  logic [WIDTH-1:0] hi_nx, lo_nx;
  logic [WIDTH:0]   add_sum, mul_sum, shifted, trial;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    hi_nx   = hi_q;
    lo_nx   = lo_q;
    add_sum = {1'b0, hi_q} + {1'b0, opnd_q};
    mul_sum = lo_q[0] ? add_sum : {1'b0, hi_q};
    shifted = {hi_q, lo_q[WIDTH-1]};
    trial   = shifted - {1'b0, opnd_q};
    if (div_q) begin
      // Partial remainder stays below the divisor, so a negative trial means "restore".
      if (!trial[WIDTH]) begin
        hi_nx = trial[WIDTH-1:0];
        lo_nx = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_nx = shifted[WIDTH-1:0];
        lo_nx = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nx = mul_sum[WIDTH:1];
      lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge Clock_in) begin
    // NOTE: sequential state uses non-blocking assignments only; the operand
    // registers are reset too, so an aborted operation leaves nothing behind.
    if (!Reset_n_in) begin
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      count_q <= '0;
    end else if (load) begin
      hi_q    <= '0;
      lo_q    <= A;
      opnd_q  <= B;
      div_q   <= is_div;
      count_q <= CNT_W'(WIDTH);
    end else if (count_q != '0) begin
      hi_q    <= hi_nx;
      lo_q    <= lo_nx;
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign product_hi = hi_nx;
  assign product_lo = lo_nx;
  assign quotient   = lo_nx;
  assign remainder  = hi_nx;
  assign count      = count_q;

endmodule

// File: rtl/ula_seq.sv
// Sequential ALU top: IDLE/CALC/DONE handshake FSM, single-cycle datapath and flag encoder.
// Results, remainder and flags are registered only on the edge that enters DONE.
module ula_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic      Clock_in,
  input  logic      Reset_n_in,
  ula_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int MSB   = WIDTH - 1;

  state_t           state_q, state_nx;
  logic [WIDTH-1:0] saida_q, resto_q, saida_nx, resto_nx;
  logic [2:0]       flags_q, flags_nx;
  logic             is_div_q;
  logic             md_load, capture;
  logic             err, ovf, cy;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   ext;
  logic             alu_cy, alu_ovf;

  logic [WIDTH-1:0] product_hi, product_lo, quotient, remainder;
  logic [CNT_W-1:0] md_count;

  ula_seq_muldiv #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_muldiv (
    .Clock_in   (Clock_in),
    .Reset_n_in (Reset_n_in),
    .load       (md_load),
    .is_div     (bus.Operacao_in == OP_DIV),
    .A          (bus.A_in),
    .B          (bus.B_in),
    .product_hi (product_hi),
    .product_lo (product_lo),
    .quotient   (quotient),
    .remainder  (remainder),
    .count      (md_count)
  );

  always_comb begin
    alu_res = '0;
    alu_cy  = 1'b0;
    alu_ovf = 1'b0;
    ext     = '0;
    unique case (bus.Operacao_in)
      OP_ADD: begin
        ext     = {1'b0, bus.A_in} + {1'b0, bus.B_in} + {{WIDTH{1'b0}}, bus.C_in};
        alu_res = ext[WIDTH-1:0];
        alu_cy  = ext[WIDTH];
        alu_ovf = (bus.A_in[MSB] == bus.B_in[MSB]) && (alu_res[MSB] != bus.A_in[MSB]);
      end
      OP_SUB: begin
        // Bit WIDTH of the extended difference is set exactly when A < B + C_in.
        ext     = {1'b0, bus.A_in} - {1'b0, bus.B_in} - {{WIDTH{1'b0}}, bus.C_in};
        alu_res = ext[WIDTH-1:0];
        alu_cy  = ext[WIDTH];
        alu_ovf = (bus.A_in[MSB] != bus.B_in[MSB]) && (alu_res[MSB] != bus.A_in[MSB]);
      end
      OP_AND:  alu_res = bus.A_in & bus.B_in;
      OP_OR:   alu_res = bus.A_in | bus.B_in;
      OP_XOR:  alu_res = bus.A_in ^ bus.B_in;
      OP_NOT:  alu_res = ~bus.A_in;
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state_q;
    md_load  = 1'b0;
    capture  = 1'b0;
    saida_nx = saida_q;
    resto_nx = resto_q;
    err      = 1'b0;
    ovf      = 1'b0;
    cy       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.Start_in) begin
          if (bus.Operacao_in == OP_MUL ||
              (bus.Operacao_in == OP_DIV && bus.B_in != '0)) begin
            state_nx = ST_CALC;
            md_load  = 1'b1;
          end else begin
            state_nx = ST_DONE;
            capture  = 1'b1;
            if (bus.Operacao_in == OP_DIV) begin
              saida_nx = '1;
              resto_nx = bus.A_in;
              err      = 1'b1;
            end else begin
              saida_nx = alu_res;
              resto_nx = '0;
              ovf      = alu_ovf;
              cy       = alu_cy;
            end
          end
        end
      end
      ST_CALC: begin
        if (md_count == CNT_W'(1)) begin
          state_nx = ST_DONE;
          capture  = 1'b1;
          if (is_div_q) begin
            saida_nx = quotient;
            resto_nx = remainder;
          end else begin
            saida_nx = product_lo;
            resto_nx = '0;
            ovf      = (product_hi != '0);
          end
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    flags_nx = encode_flags(err, ovf, cy, saida_nx == '0);
  end

  always_ff @(posedge Clock_in) begin
    if (!Reset_n_in) begin
      state_q  <= ST_IDLE;
      saida_q  <= '0;
      resto_q  <= '0;
      flags_q  <= FLAG_NONE;
      is_div_q <= 1'b0;
    end else begin
      state_q <= state_nx;
      if (capture) begin
        saida_q <= saida_nx;
        resto_q <= resto_nx;
        flags_q <= flags_nx;
      end
      if (md_load) is_div_q <= (bus.Operacao_in == OP_DIV);
    end
  end

  assign bus.Busy_out  = (state_q != ST_IDLE);
  assign bus.Done_out  = (state_q == ST_DONE);
  assign bus.Saida_out = saida_q;
  assign bus.Resto_out = resto_q;
  assign bus.Flags_out = flags_q;

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq (WIDTH=8): latency, results, flags, abort by reset, back-to-back.
module tb_ula_seq;
  import ula_pkg::*;

  localparam int LAT_MAX = 40;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ula_seq_if #(.WIDTH(8)) bus ();

  ula_seq #(.WIDTH(8)) dut (
    .Clock_in   (clk),
    .Reset_n_in (rst_n),
    .bus        (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request, waits for Done and checks latency, busy span, results and hold.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input int exp_lat, input logic [7:0] exp_s,
                        input logic [7:0] exp_r, input logic [2:0] exp_f);
    int n, busy_n, hold_bad;
    logic [7:0] prev_s;
    prev_s = bus.Saida_out;
    bus.Operacao_in = op;
    bus.A_in        = a;
    bus.B_in        = b;
    bus.C_in        = cin;
    bus.Start_in    = 1'b1;
    step();
    bus.Start_in = 1'b0;
    n = 1; busy_n = 0; hold_bad = 0;
    while (!bus.Done_out && n <= LAT_MAX) begin
      if (bus.Busy_out) busy_n++;
      if (bus.Saida_out !== prev_s) hold_bad++;
      step();
      n++;
    end
    if (bus.Busy_out) busy_n++;
    check({tag, "_lat"},   n,             exp_lat);
    check({tag, "_busy"},  busy_n,        exp_lat);
    check({tag, "_hold"},  hold_bad,      0);
    check({tag, "_saida"}, bus.Saida_out, exp_s);
    check({tag, "_resto"}, bus.Resto_out, exp_r);
    check({tag, "_flags"}, bus.Flags_out, exp_f);
    step();
    check({tag, "_pulse"},  bus.Done_out,  0);
    check({tag, "_idle"},   bus.Busy_out,  0);
    check({tag, "_kept"},   bus.Saida_out, exp_s);
  endtask

  initial begin
    int done_n, consec;
    logic prev_done;

    rst_n = 1'b0;
    bus.Start_in = 1'b0; bus.A_in = '0; bus.B_in = '0; bus.C_in = 1'b0;
    bus.Operacao_in = OP_ADD;
    step(); step();
    check("rst_busy",  bus.Busy_out,  0);
    check("rst_done",  bus.Done_out,  0);
    check("rst_saida", bus.Saida_out, 0);
    check("rst_resto", bus.Resto_out, 0);
    check("rst_flags", bus.Flags_out, 0);
    rst_n = 1'b1;
    step();

    //     tag         op      A      B      C  lat  saida  resto  flags
    run_op("add_ovf",  OP_ADD, 8'h7F, 8'h01, 0, 1,   8'h80, 8'h00, 3'b111);
    run_op("add_cy",   OP_ADD, 8'hFF, 8'h01, 0, 1,   8'h00, 8'h00, 3'b010);
    run_op("sub_zero", OP_SUB, 8'h05, 8'h05, 0, 1,   8'h00, 8'h00, 3'b001);
    run_op("add_cin",  OP_ADD, 8'h10, 8'h20, 1, 1,   8'h31, 8'h00, 3'b000);
    run_op("sub_brw",  OP_SUB, 8'h03, 8'h05, 0, 1,   8'hFE, 8'h00, 3'b010);
    run_op("sub_cin",  OP_SUB, 8'h10, 8'h0F, 1, 1,   8'h00, 8'h00, 3'b001);
    run_op("and",      OP_AND, 8'hF0, 8'h3C, 0, 1,   8'h30, 8'h00, 3'b000);
    run_op("or",       OP_OR,  8'hF0, 8'h0C, 1, 1,   8'hFC, 8'h00, 3'b000);
    run_op("xor_zero", OP_XOR, 8'hAA, 8'hAA, 0, 1,   8'h00, 8'h00, 3'b001);
    run_op("not",      OP_NOT, 8'h5A, 8'h00, 0, 1,   8'hA5, 8'h00, 3'b000);
    run_op("mul_ovf",  OP_MUL, 8'h10, 8'h10, 0, 9,   8'h00, 8'h00, 3'b111);
    run_op("mul",      OP_MUL, 8'd12, 8'd11, 0, 9,   8'h84, 8'h00, 3'b000);
    run_op("div",      OP_DIV, 8'd200, 8'd7, 0, 9,   8'd28, 8'd4,  3'b000);
    run_op("div_zq",   OP_DIV, 8'd5,  8'd9,  0, 9,   8'd0,  8'd5,  3'b001);
    run_op("div_by0",  OP_DIV, 8'd9,  8'd0,  0, 1,   8'hFF, 8'd9,  3'b100);

    // Abort an in-flight DIV: ignored Start at k+3, reset sampled at k+5.
    done_n = 0;
    bus.Operacao_in = OP_DIV; bus.A_in = 8'd100; bus.B_in = 8'd3; bus.Start_in = 1'b1;
    step();
    bus.Start_in = 1'b0;
    done_n += int'(bus.Done_out);
    step(); done_n += int'(bus.Done_out);
    step(); done_n += int'(bus.Done_out);
    bus.Operacao_in = OP_ADD; bus.A_in = 8'd1; bus.B_in = 8'd1; bus.Start_in = 1'b1;
    step();
    bus.Start_in = 1'b0;
    check("abort_ign_done", bus.Done_out, 0);
    check("abort_ign_busy", bus.Busy_out, 1);
    step(); done_n += int'(bus.Done_out);
    rst_n = 1'b0;
    step();
    check("abort_busy",  bus.Busy_out,  0);
    check("abort_done",  bus.Done_out,  0);
    check("abort_saida", bus.Saida_out, 0);
    check("abort_resto", bus.Resto_out, 0);
    check("abort_flags", bus.Flags_out, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      done_n += int'(bus.Done_out);
    end
    check("abort_no_done", done_n, 0);

    // Start held high: one result every two cycles, never two Done cycles in a row.
    done_n = 0; consec = 0; prev_done = 1'b0;
    bus.Operacao_in = OP_ADD; bus.A_in = 8'h40; bus.B_in = 8'h3F; bus.C_in = 1'b1;
    bus.Start_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.Done_out) done_n++;
      if (bus.Done_out && prev_done) consec++;
      prev_done = bus.Done_out;
    end
    bus.Start_in = 1'b0;
    check("b2b_count",  done_n, 10);
    check("b2b_consec", consec, 0);
    step();
    check("b2b_saida", bus.Saida_out, 8'h80);
    check("b2b_flags", bus.Flags_out, 3'b111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
